adaptive_fir_mac: RTL and testbench
===================================

ADAPTIVE_FIR_MAC -- requirements
Module: adaptive_fir_mac

Interface
REQ-001 SHALL have parameter TAPS, default 32: filter length, range 2..64.
REQ-002 SHALL have parameter XW, default 14: reference, desired and error sample width, signed.
REQ-003 SHALL have parameter WW, default 16: coefficient width, signed.
REQ-004 SHALL have parameter FRAC, default 10: coefficient fractional bits, range 1..WW-1.
REQ-005 SHALL have port clk, input, 1: single clock; all logic SHALL be on its rising edge.
REQ-006 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port start, input, 1: single-cycle request to filter one sample.
REQ-008 SHALL have port x_flat, input, TAPS*XW: tap vector; tap k occupies bits [k*XW +: XW]; tap 0 is the newest sample.
REQ-009 SHALL have port w_flat, input, TAPS*WW: coefficient vector, packed the same way as x_flat.
REQ-010 SHALL have port d_in, input, XW: desired sample.
REQ-011 SHALL have port sat_en, input, 1: 1 = saturate y and e, 0 = wrap (two's-complement truncation).
REQ-012 SHALL have port busy, output, 1: high while a computation is in progress.
REQ-013 SHALL have port done, output, 1: one-cycle pulse when results update.
REQ-014 SHALL have port y, output, XW: filter output, signed.
REQ-015 SHALL have port e, output, XW: error d_in - y, signed.
REQ-016 SHALL have port energy, output, 2*XW+clog2(TAPS): sum of x[k]^2, unsigned, floored at 1.

Function
REQ-017 SHALL implement FSM states IDLE, MAC, DRAIN, FINISH:
 - IDLE -> MAC on start.
 - MAC -> DRAIN after TAPS tap issues.
 - DRAIN -> FINISH after 2 cycles.
 - FINISH -> IDLE after 1 cycle.
REQ-018 SHALL, on a start edge in IDLE, snapshot x_flat, w_flat, d_in and sat_en into registers; input changes after that edge SHALL have no effect on the current computation.
REQ-019 SHALL ignore start whenever the state is not IDLE: no queueing, no restart.
REQ-020 SHALL issue taps TAPS-1 down to 0, one per cycle, through a 2-stage pipeline:
 - stage 1: registered products w*x (XW+WW bits) and x*x (2*XW bits);
 - stage 2: sign-extended accumulation into a y accumulator of XW+WW+clog2(TAPS) bits and an energy accumulator.
REQ-021 SHALL clear both accumulators on the start edge.
REQ-022 SHALL assert done exactly TAPS+3 cycles after the start edge, for one cycle.
REQ-023 SHALL update y, e and energy on the same edge that asserts done, and hold them until the next done.
REQ-024 SHALL hold busy high from the cycle after the start edge through the done cycle, inclusive.
REQ-025 SHALL compute y as (acc + 2^(FRAC-1)) arithmetically shifted right by FRAC (round half up).
REQ-026 SHALL, with sat_en=1, clamp y to [-2^(XW-1), 2^(XW-1)-1]; with sat_en=0, SHALL take the low XW bits.
REQ-027 SHALL compute e = d_in - y at XW+1 bits, then saturate or wrap per sat_en.
REQ-028 SHALL output energy = max(sum, 1), so that a downstream normaliser never divides by zero.
REQ-029 SHALL permit start in the cycle after done (back-to-back operation); the throughput limit is one sample per TAPS+4 cycles.

Reset
REQ-030 SHALL, when rst=1 at a clock edge, enter IDLE and set busy=0, done=0, y=0, e=0, energy=1, and clear the accumulators and pipeline.
REQ-031 SHALL, on rst during MAC, DRAIN or FINISH, abort the computation with no done pulse; start in the same cycle as rst SHALL be ignored.

Structure
REQ-032 SHALL take the FSM state encoding, the default parameter values and the clog2-derived accumulator widths from shared package adaptive_pkg.
REQ-033 SHALL contain one sub-module, fir_mac_stage: the registered product pair plus the accumulators, parametrised by XW and WW.

Verification
REQ-034 TAPS=4, FRAC=10, x={100,200,300,400}, all w=1024, d_in=1000, sat_en=1 -> y=1000, e=0, energy=300000, done at cycle 7.
REQ-035 TAPS=4, all x=8191, all w=32767, sat_en=1 -> y=8191 (clamped), e=d_in-8191 clamped; repeat with sat_en=0 -> y equals the low 14 bits of the rounded value.
REQ-036 All x=0 -> energy=1, y=0, e=d_in.
REQ-037 start pulsed again at cycles 2 and 5 after the first start -> exactly one done pulse; results reflect the first snapshot only.
REQ-038 rst asserted at cycle 3 of MAC -> no done pulse, y=0, e=0, energy=1; a following start completes normally after TAPS+3 cycles.
REQ-039 Rounding check, FRAC=10, single nonzero tap x=1, w=512 -> y=1; with w=511 -> y=0; with w=-512 -> y=0.

Source files
------------

// File: rtl/adaptive_pkg.sv
// Shared definitions for the adaptive FIR multiply-accumulate block:
// FSM state encoding, default parameter values and accumulator widths.
package adaptive_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      MAC    = 2'd1,
      DRAIN  = 2'd2,
      FINISH = 2'd3
   } state_e;

   localparam int DEF_TAPS = 32;
   localparam int DEF_XW   = 14;
   localparam int DEF_WW   = 16;
   localparam int DEF_FRAC = 10;

   // Width of the y accumulator: full product plus headroom for TAPS terms.
   function automatic int accWidth(input int xw, input int ww, input int taps);
      return xw + ww + $clog2(taps);
   endfunction

   // Width of the energy accumulator: full square plus headroom for TAPS terms.
   function automatic int energyWidth(input int xw, input int taps);
      return 2 * xw + $clog2(taps);
   endfunction

endpackage

// File: rtl/fir_mac_stage.sv
// Two-stage datapath: registered w*x and x*x products, followed by
// sign-extending accumulators for the filter sum and the tap energy.
module fir_mac_stage
   import adaptive_pkg::*;
#(
   parameter int XW   = DEF_XW,
   parameter int WW   = DEF_WW,
   parameter int TAPS = DEF_TAPS
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                clear_i,
   input  logic                                issue_i,
   input  logic [XW-1:0]                       x_i,
   input  logic [WW-1:0]                       w_i,
   output logic [accWidth(XW, WW, TAPS)-1:0]   acc_o,
   output logic [energyWidth(XW, TAPS)-1:0]    energy_o
);

   localparam int PW    = XW + WW;
   localparam int SW    = 2 * XW;
   localparam int ACC_W = accWidth(XW, WW, TAPS);
   localparam int EN_W  = energyWidth(XW, TAPS);

   logic [PW-1:0]    xExt;
   logic [PW-1:0]    wExt;
   logic [PW-1:0]    prodFull;
   logic [SW-1:0]    xSqExt;
   logic [SW-1:0]    sqFull;
   logic [PW-1:0]    prod_q;
   logic [SW-1:0]    sq_q;
   logic             valid_q;
   logic [ACC_W-1:0] acc_q;
   logic [EN_W-1:0]  energy_q;

   // Operands are sign-extended to the result width, so the low bits of an
   // unsigned multiply are the exact two's-complement product.
   assign xExt     = {{WW{x_i[XW-1]}}, x_i};
   assign wExt     = {{XW{w_i[WW-1]}}, w_i};
   assign prodFull = xExt * wExt;
   assign xSqExt   = {{XW{x_i[XW-1]}}, x_i};
   assign sqFull   = xSqExt * xSqExt;

   // Stage 1: capture the product pair and mark whether it belongs to a tap.
   always_ff @(posedge clk) begin
      if (rst) begin
         prod_q  <= '0;
         sq_q    <= '0;
         valid_q <= 1'b0;
      end else begin
         prod_q  <= prodFull;
         sq_q    <= sqFull;
         valid_q <= issue_i;
      end
   end

   // Stage 2: accumulate valid products; the square is never negative, so
   // zero-extension is exact for the energy sum.
   always_ff @(posedge clk) begin
      if (rst || clear_i) begin
         acc_q    <= '0;
         energy_q <= '0;
      end else if (valid_q) begin
         acc_q    <= acc_q + {{(ACC_W-PW){prod_q[PW-1]}}, prod_q};
         energy_q <= energy_q + {{(EN_W-SW){1'b0}}, sq_q};
      end
   end

   assign acc_o    = acc_q;
   assign energy_o = energy_q;

endmodule

// File: rtl/adaptive_fir_mac.sv
// Adaptive FIR filter core: snapshots one tap/coefficient vector per start,
// walks the taps through a 2-stage MAC, then rounds, saturates or wraps the
// result and publishes y, the error d_in - y and the floored tap energy.
module adaptive_fir_mac
   import adaptive_pkg::*;
#(
   parameter int TAPS = DEF_TAPS,
   parameter int XW   = DEF_XW,
   parameter int WW   = DEF_WW,
   parameter int FRAC = DEF_FRAC
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             start,
   input  logic [TAPS*XW-1:0]               x_flat,
   input  logic [TAPS*WW-1:0]               w_flat,
   input  logic [XW-1:0]                    d_in,
   input  logic                             sat_en,
   output logic                             busy,
   output logic                             done,
   output logic [XW-1:0]                    y,
   output logic [XW-1:0]                    e,
   output logic [energyWidth(XW, TAPS)-1:0] energy
);

   localparam int TIW   = $clog2(TAPS);
   localparam int ACC_W = accWidth(XW, WW, TAPS);
   localparam int EN_W  = energyWidth(XW, TAPS);

   localparam logic signed [ACC_W-1:0] ROUND_HALF = ACC_W'(64'd1 << (FRAC - 1));
   localparam logic signed [ACC_W-1:0] Y_MAX      = ACC_W'((64'd1 << (XW - 1)) - 64'd1);
   localparam logic signed [ACC_W-1:0] Y_MIN      = ~Y_MAX;
   localparam logic [XW-1:0]           SAT_POS    = {1'b0, {(XW-1){1'b1}}};
   localparam logic [XW-1:0]           SAT_NEG    = {1'b1, {(XW-1){1'b0}}};

   state_e                   state_q, state_d;
   logic [TIW-1:0]           tapIdx_q, tapIdx_d;
   logic                     drainCnt_q, drainCnt_d;
   logic [TAPS*XW-1:0]       xSnap_q;
   logic [TAPS*WW-1:0]       wSnap_q;
   logic [XW-1:0]            dSnap_q;
   logic                     satSnap_q;
   logic [XW-1:0]            y_q, e_q;
   logic [EN_W-1:0]          energy_q;
   logic                     done_q;

   logic                     capture, issue, finish;
   logic [XW-1:0]            xTap;
   logic [WW-1:0]            wTap;
   logic signed [ACC_W-1:0]  accSum;
   logic [EN_W-1:0]          energySum;
   logic signed [ACC_W-1:0]  accRound, accShift;
   logic [XW-1:0]            yNext, eNext;
   logic [XW:0]              eFull;
   logic [EN_W-1:0]          energyNext;

   // State register; reset aborts any computation and ignores a coincident start.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         tapIdx_q   <= '0;
         drainCnt_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         tapIdx_q   <= tapIdx_d;
         drainCnt_q <= drainCnt_d;
      end
   end

   // Sequencing: accept start only in IDLE, issue taps high to low, let the
   // pipeline drain for two cycles, then publish results in FINISH.
   always_comb begin
      state_d    = state_q;
      tapIdx_d   = tapIdx_q;
      drainCnt_d = drainCnt_q;
      capture    = 1'b0;
      issue      = 1'b0;
      finish     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               capture  = 1'b1;
               tapIdx_d = TIW'(TAPS - 1);
               state_d  = MAC;
            end
         end
         MAC: begin
            issue = 1'b1;
            if (tapIdx_q == '0) begin
               drainCnt_d = 1'b0;
               state_d    = DRAIN;
            end else begin
               tapIdx_d = tapIdx_q - TIW'(1);
            end
         end
         DRAIN: begin
            if (drainCnt_q) begin
               state_d = FINISH;
            end else begin
               drainCnt_d = 1'b1;
            end
         end
         FINISH: begin
            finish  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Snapshot of the operands so later input changes cannot disturb the run.
   always_ff @(posedge clk) begin
      if (rst) begin
         xSnap_q   <= '0;
         wSnap_q   <= '0;
         dSnap_q   <= '0;
         satSnap_q <= 1'b0;
      end else if (capture) begin
         xSnap_q   <= x_flat;
         wSnap_q   <= w_flat;
         dSnap_q   <= d_in;
         satSnap_q <= sat_en;
      end
   end

   // Select the tap currently being issued from the snapshot.
   always_comb begin
      xTap = '0;
      wTap = '0;
      for (int k = 0; k < TAPS; k++) begin
         if (tapIdx_q == TIW'(k)) begin
            xTap = xSnap_q[k*XW +: XW];
            wTap = wSnap_q[k*WW +: WW];
         end
      end
   end

   fir_mac_stage #(
      .XW   (XW),
      .WW   (WW),
      .TAPS (TAPS)
   ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .clear_i  (capture),
      .issue_i  (issue),
      .x_i      (xTap),
      .w_i      (wTap),
      .acc_o    (accSum),
      .energy_o (energySum)
   );

   // Round half up, then clamp or wrap y; form the error one bit wider so
   // the subtraction itself cannot overflow before clamping or wrapping.
   always_comb begin
      accRound = accSum + ROUND_HALF;
      accShift = accRound >>> FRAC;
      yNext    = accShift[XW-1:0];
      if (satSnap_q) begin
         if (accShift > Y_MAX) begin
            yNext = SAT_POS;
         end else if (accShift < Y_MIN) begin
            yNext = SAT_NEG;
         end
      end
      eFull = {dSnap_q[XW-1], dSnap_q} - {yNext[XW-1], yNext};
      eNext = eFull[XW-1:0];
      if (satSnap_q && (eFull[XW] != eFull[XW-1])) begin
         eNext = eFull[XW] ? SAT_NEG : SAT_POS;
      end
      energyNext = (energySum == '0) ? EN_W'(1) : energySum;
   end

   // Result registers update together with the done pulse and hold otherwise.
   always_ff @(posedge clk) begin
      if (rst) begin
         y_q      <= '0;
         e_q      <= '0;
         energy_q <= EN_W'(1);
         done_q   <= 1'b0;
      end else begin
         done_q <= finish;
         if (finish) begin
            y_q      <= yNext;
            e_q      <= eNext;
            energy_q <= energyNext;
         end
      end
   end

   assign busy   = (state_q != IDLE) || done_q;
   assign done   = done_q;
   assign y      = y_q;
   assign e      = e_q;
   assign energy = energy_q;

endmodule

// File: tb/tb_adaptive_fir_mac.sv
// Self-checking bench for adaptive_fir_mac (TAPS=4) with a plain-arithmetic
// reference model for y, e and energy.
module tb_adaptive_fir_mac;

   localparam int TAPS = 4;
   localparam int XW   = 14;
   localparam int WW   = 16;
   localparam int FRAC = 10;
   localparam int EW   = 2 * XW + 2;
   localparam int XV   = TAPS * XW;
   localparam int WV   = TAPS * WW;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [XV-1:0] x_flat;
   logic [WV-1:0] w_flat;
   logic [XW-1:0] d_in;
   logic          sat_en;
   logic          busy;
   logic          done;
   logic [XW-1:0] y;
   logic [XW-1:0] e;
   logic [EW-1:0] energy;

   int checks   = 0;
   int failures = 0;

   adaptive_fir_mac #(
      .TAPS (TAPS),
      .XW   (XW),
      .WW   (WW),
      .FRAC (FRAC)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .x_flat (x_flat),
      .w_flat (w_flat),
      .d_in   (d_in),
      .sat_en (sat_en),
      .busy   (busy),
      .done   (done),
      .y      (y),
      .e      (e),
      .energy (energy)
   );

   // Free-running clock, 10 time units per cycle.
   initial forever #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input longint observed, input longint expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [XV-1:0] xv, input logic [WV-1:0] wv,
                                input logic [XW-1:0] d, input logic s);
      x_flat = xv;
      w_flat = wv;
      d_in   = d;
      sat_en = s;
   endtask

   task automatic scrambleInputs();
      applyStimulus(XV'({$urandom(), $urandom()}), WV'({$urandom(), $urandom()}),
                    XW'($urandom()), 1'($urandom_range(0, 1)));
   endtask

   function automatic longint clampTo(input longint v, input int bits);
      longint hi, lo;
      hi = (longint'(1) << (bits - 1)) - 1;
      lo = -(longint'(1) << (bits - 1));
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

   function automatic longint wrapTo(input longint v, input int bits);
      longint m, r;
      m = longint'(1) << bits;
      r = v % m;
      if (r < 0) r += m;
      if (r >= m / 2) r -= m;
      return r;
   endfunction

   // Reference: dot product, round half up by adding half an LSB and
   // flooring the division, then clamp or wrap; energy is the sum of squares.
   task automatic computeExpected(input logic [XV-1:0] xv, input logic [WV-1:0] wv,
                                  input logic [XW-1:0] d, input logic s,
                                  output longint ey, output longint ee, output longint een);
      longint acc, sq, xs, ws, ds, r;
      logic signed [XW-1:0] xt;
      logic signed [WW-1:0] wt;
      logic signed [XW-1:0] dt;
      acc = 0;
      sq  = 0;
      for (int k = 0; k < TAPS; k++) begin
         xt = xv[k*XW +: XW];
         wt = wv[k*WW +: WW];
         xs = longint'(xt);
         ws = longint'(wt);
         acc += xs * ws;
         sq  += xs * xs;
      end
      r  = (acc + (longint'(1) << (FRAC - 1))) >>> FRAC;
      ey = s ? clampTo(r, XW) : wrapTo(r, XW);
      dt = d;
      ds = longint'(dt);
      ee = s ? clampTo(ds - ey, XW) : wrapTo(ds - ey, XW);
      een = (sq < 1) ? 1 : sq;
   endtask

   // Full transaction: start, scramble inputs, wait for done (bounded),
   // compare latency, busy and results; optionally leave the bench sitting
   // in the done cycle so the caller can start again immediately.
   task automatic runOp(input string tag, input logic [XV-1:0] xv, input logic [WV-1:0] wv,
                        input logic [XW-1:0] d, input logic s, input bit b2b);
      longint ey, ee, een;
      int cycles;
      bit busyLow;
      computeExpected(xv, wv, d, s, ey, ee, een);
      applyStimulus(xv, wv, d, s);
      start = 1'b1;
      tick();
      start = 1'b0;
      scrambleInputs();
      cycles  = 0;
      busyLow = 1'b0;
      while (done !== 1'b1 && cycles < 40) begin
         tick();
         cycles++;
         if (done !== 1'b1 && busy !== 1'b1) busyLow = 1'b1;
      end
      checkOutput({tag, ".latency"}, cycles, TAPS + 3);
      checkOutput({tag, ".busyLow"}, longint'(busyLow), 0);
      checkOutput({tag, ".busyAtDone"}, longint'(busy), 1);
      checkOutput({tag, ".y"}, longint'($signed(y)), ey);
      checkOutput({tag, ".e"}, longint'($signed(e)), ee);
      checkOutput({tag, ".energy"}, longint'(energy), een);
      if (!b2b) begin
         tick();
         checkOutput({tag, ".doneDrop"}, longint'(done), 0);
         checkOutput({tag, ".busyDrop"}, longint'(busy), 0);
         checkOutput({tag, ".yHold"}, longint'($signed(y)), ey);
      end
   endtask

   function automatic logic [XV-1:0] packX(input int v0, input int v1, input int v2, input int v3);
      logic [XV-1:0] r;
      r[0*XW +: XW] = XW'(v0);
      r[1*XW +: XW] = XW'(v1);
      r[2*XW +: XW] = XW'(v2);
      r[3*XW +: XW] = XW'(v3);
      return r;
   endfunction

   function automatic logic [WV-1:0] fillW(input int v);
      logic [WV-1:0] r;
      for (int k = 0; k < TAPS; k++) r[k*WW +: WW] = WW'(v);
      return r;
   endfunction

   initial begin
      logic [XV-1:0] xv;
      logic [WV-1:0] wv;
      logic [XW-1:0] dv;
      longint ey, ee, een;
      int pulses, doneAt;
      longint capY, capE, capEn;
      int tapSel;

      rst   = 1'b1;
      start = 1'b0;
      applyStimulus('0, '0, '0, 1'b0);
      tick();
      tick();
      rst = 1'b0;
      checkOutput("reset.busy", longint'(busy), 0);
      checkOutput("reset.done", longint'(done), 0);
      checkOutput("reset.y", longint'($signed(y)), 0);
      checkOutput("reset.e", longint'($signed(e)), 0);
      checkOutput("reset.energy", longint'(energy), 1);

      // Nominal case: unity gain coefficients reproduce the tap sum.
      runOp("nominal", packX(100, 200, 300, 400), fillW(1024), XW'(1000), 1'b1, 1'b0);
      checkOutput("nominal.yConst", longint'($signed(y)), 1000);
      checkOutput("nominal.energyConst", longint'(energy), 300000);

      // Full-scale taps and coefficients: saturated, then wrapped.
      dv = XW'($urandom());
      runOp("fullSat", packX(8191, 8191, 8191, 8191), fillW(32767), dv, 1'b1, 1'b0);
      checkOutput("fullSat.yConst", longint'($signed(y)), 8191);
      runOp("fullWrap", packX(8191, 8191, 8191, 8191), fillW(32767), dv, 1'b0, 1'b0);
      checkOutput("fullWrap.yConst", longint'($signed(y)), -160);

      // All-zero taps: energy floors at one and the error is the desired sample.
      runOp("zeroTaps", '0, WV'({$urandom(), $urandom()}), XW'(-1234), 1'b1, 1'b0);
      checkOutput("zeroTaps.eConst", longint'($signed(e)), -1234);

      // Rounding boundary with one nonzero tap.
      tapSel = $urandom_range(0, TAPS - 1);
      xv = '0;
      xv[tapSel*XW +: XW] = XW'(1);
      runOp("round512", xv, fillW(512), XW'(0), 1'b1, 1'b0);
      checkOutput("round512.yConst", longint'($signed(y)), 1);
      runOp("round511", xv, fillW(511), XW'(0), 1'b1, 1'b0);
      checkOutput("round511.yConst", longint'($signed(y)), 0);
      runOp("roundNeg512", xv, fillW(-512), XW'(0), 1'b1, 1'b0);
      checkOutput("roundNeg512.yConst", longint'($signed(y)), 0);

      // Extra start pulses during the run must be ignored.
      xv = packX(-300, 1200, 77, -4000);
      wv = fillW(900);
      dv = XW'(500);
      computeExpected(xv, wv, dv, 1'b1, ey, ee, een);
      applyStimulus(xv, wv, dv, 1'b1);
      start = 1'b1;
      tick();
      start = 1'b0;
      pulses = 0;
      doneAt = 0;
      capY = 0;
      capE = 0;
      capEn = 0;
      for (int c = 1; c <= 20; c++) begin
         start = (c == 2 || c == 5);
         if (start) scrambleInputs();
         tick();
         start = 1'b0;
         if (done === 1'b1) begin
            pulses++;
            doneAt = c;
            capY  = longint'($signed(y));
            capE  = longint'($signed(e));
            capEn = longint'(energy);
         end
      end
      checkOutput("restart.pulses", pulses, 1);
      checkOutput("restart.doneAt", doneAt, TAPS + 3);
      checkOutput("restart.y", capY, ey);
      checkOutput("restart.e", capE, ee);
      checkOutput("restart.energy", capEn, een);

      // Reset in the middle of MAC: no done, results cleared, start ignored.
      runOp("preAbort", packX(100, 200, 300, 400), fillW(1024), XW'(-50), 1'b1, 1'b0);
      applyStimulus(packX(1, 2, 3, 4), fillW(2048), XW'(7), 1'b1);
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      rst   = 1'b1;
      start = 1'b1;
      tick();
      rst   = 1'b0;
      start = 1'b0;
      checkOutput("abort.busy", longint'(busy), 0);
      pulses = 0;
      for (int c = 0; c < 15; c++) begin
         tick();
         if (done === 1'b1) pulses++;
      end
      checkOutput("abort.pulses", pulses, 0);
      checkOutput("abort.y", longint'($signed(y)), 0);
      checkOutput("abort.e", longint'($signed(e)), 0);
      checkOutput("abort.energy", longint'(energy), 1);
      runOp("postAbort", packX(-5, 60, -700, 8000), fillW(-3000), XW'(300), 1'b1, 1'b0);

      // Randomized transactions, some started straight out of the done cycle.
      for (int i = 0; i < 16; i++) begin
         for (int k = 0; k < TAPS; k++) begin
            xv[k*XW +: XW] = XW'($urandom());
            if (i % 2 == 1) wv[k*WW +: WW] = WW'($urandom());
            else wv[k*WW +: WW] = WW'(int'($urandom_range(0, 4095)) - 2048);
         end
         runOp($sformatf("rand%0d", i), xv, wv, XW'($urandom()), 1'($urandom_range(0, 1)),
               (i % 3 == 0));
      end
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
